ped_button_conditioner: RTL and testbench



---
 rtl/traffic_pkg.sv | 30 +++
 rtl/debounce_filter.sv | 56 +++++
 rtl/ped_button_conditioner.sv | 63 ++++++
 tb/tb_ped_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the pedestrian crossing: the Traffic controller and
// the push-button conditioner import this one package.
//   DEFAULT_DEBOUNCE  default qualification length of the button debouncer
//   lamp_e            aspect shown by a single lamp head
//   traffic_state_e   top-level phases of the Traffic controller
//   lamps_t           car and pedestrian lamp pair as driven by Traffic
package traffic_pkg;

  localparam int DEFAULT_DEBOUNCE = 4;

  typedef enum logic [1:0] {
    LAMP_OFF,
    LAMP_RED,
    LAMP_AMBER,
    LAMP_GREEN
  } lamp_e;

  typedef enum logic [1:0] {
    ST_CAR_GREEN,
    ST_CAR_AMBER,
    ST_PED_GREEN,
    ST_ALL_RED
  } traffic_state_e;

  typedef struct packed {
    lamp_e car;
    lamp_e ped;
  } lamps_t;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a symmetric debouncer.
//   clk, rst  single clock, synchronous active-high reset
//   i_raw     asynchronous contact level
//   o_db      debounced level (registered)
//   o_rise    one-cycle strobe in the cycle whose edge raises o_db
// A new level is accepted only after it has been seen on the synchronised
// signal for DEBOUNCE_CYCLES consecutive cycles; any cycle back at the old
// level restarts qualification, for presses and releases alike.
module debounce_filter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_db,
  output logic o_rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [DW-1:0] r_dcnt;
  logic          w_qualified;

  // The last cycle of a disagreeing run: the next edge adopts the new level.
  assign w_qualified = (r_sync2 != r_db) && (r_dcnt == DMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_dcnt <= '0;
      end else if (w_qualified) begin
        r_db   <= r_sync2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = w_qualified && r_sync2;

endmodule

// File: rtl/ped_button_conditioner.sv
// Pedestrian push-button conditioner in front of Traffic.button.
//   clk, rst     single clock, synchronous active-high reset
//   button_raw   asynchronous, bouncing contact (1 = pressed)
//   green_p      pedestrian green from Traffic; clears the pending request
//   button       latched crossing request (registered)
//   press_count  saturating count of debounced presses (registered)
// Each debounced press latches a request that persists until Traffic shows
// pedestrian green. Service wins over a coincident press, so a press made
// during green is counted but not latched.
module ped_button_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button_raw,
  input  logic             green_p,
  output logic             button,
  output logic [CNT_W-1:0] press_count
);

  logic             w_db;
  logic             w_rise;
  logic             w_press;
  logic             r_req;
  logic [CNT_W-1:0] r_cnt;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .i_raw (button_raw),
    .o_db  (w_db),
    .o_rise(w_rise)
  );

  // A press is a qualified rise away from a released level; holding the
  // button keeps db high, so no further press appears until a release.
  assign w_press = w_rise && !w_db;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (green_p) begin
        r_req <= 1'b0;
      end else if (w_press) begin
        r_req <= 1'b1;
      end
      if (w_press && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign button      = r_req;
  assign press_count = r_cnt;

endmodule

// File: tb/tb_ped_button_conditioner.sv
module tb_ped_button_conditioner;

  localparam int DEB = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       button_raw = 1'b0;
  logic       green_p = 1'b0;
  logic       button_a;
  logic [7:0] cnt_a;
  logic       button_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ped_button_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .button_raw(button_raw), .green_p(green_p),
    .button(button_a), .press_count(cnt_a)
  );

  ped_button_conditioner #(.DEBOUNCE_CYCLES(DEB), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .button_raw(button_raw), .green_p(green_p),
    .button(button_b), .press_count(cnt_b)
  );

  // ---------------- reference model ----------------
  // m_pipe: raw samples still travelling through the two-stage synchroniser.
  // m_win : most recent synchronised samples; a level change is accepted when
  //         the last DEB of them all disagree with the accepted level.
  bit m_pipe[$];
  bit m_win[$];
  bit m_db;
  bit m_req;
  int m_cnt_a;
  int m_cnt_b;

  function automatic void model_reset();
    m_pipe = {1'b0, 1'b0};
    m_win  = {};
    m_db   = 1'b0;
    m_req  = 1'b0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endfunction

  // Advance one clock edge and update the model with the inputs at that edge;
  // returns 1 ns after the edge, when outputs are safe to sample.
  task automatic tick();
    bit s;
    bit all_diff;
    bit press;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(button_raw);
      m_win.push_back(s);
      if (m_win.size() > DEB) void'(m_win.pop_front());
      press = 1'b0;
      if (m_win.size() == DEB) begin
        all_diff = 1'b1;
        foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
          m_db  = ~m_db;
          press = m_db;
          m_win = {};
        end
      end
      if (green_p)    m_req = 1'b0;
      else if (press) m_req = 1'b1;
      if (press) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; button_raw = 1'b1; green_p = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (button_a !== 1'b0) $display("FAIL reset_button: got %b want 0", button_a);
      else n_pass++;
      n_checks++;
      if (cnt_a !== 8'd0 || cnt_b !== 2'd0)
        $display("FAIL reset_count: got %0d/%0d want 0/0", cnt_a, cnt_b);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (button_a !== 1'b0 || cnt_a !== 8'd0)
      $display("FAIL post_reset: got button=%b count=%0d want 0/0", button_a, cnt_a);
    else n_pass++;
    button_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_clean_press();
    button_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (button_a !== (k >= 6))
        $display("FAIL clean_button edge %0d: got %b want %b", k, button_a, (k >= 6));
      else n_pass++;
      n_checks++;
      if (cnt_a !== ((k >= 6) ? 8'd1 : 8'd0))
        $display("FAIL clean_count edge %0d: got %0d want %0d", k, cnt_a, (k >= 6) ? 1 : 0);
      else n_pass++;
    end
    button_raw = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (button_a !== 1'b1) $display("FAIL held_after_release: got %b want 1", button_a);
      else n_pass++;
    end
  endtask

  task automatic test_service();
    button_raw = 1'b1;
    repeat (8) tick();
    n_checks++;
    if (button_a !== 1'b1 || cnt_a !== 8'(m_cnt_a))
      $display("FAIL service_pre: got button=%b count=%0d want 1/%0d", button_a, cnt_a, m_cnt_a);
    else n_pass++;
    green_p = 1'b1;
    tick();
    green_p = 1'b0;
    n_checks++;
    if (button_a !== 1'b0) $display("FAIL service_clear: got %b want 0", button_a);
    else n_pass++;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (button_a !== 1'b0 || button_b !== 1'b0)
        $display("FAIL service_held: got %b/%b want 0", button_a, button_b);
      else n_pass++;
    end
    button_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_bounce();
    bit       pat[7];
    int       c0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    c0 = m_cnt_a;
    for (int i = 0; i < 17; i++) begin
      button_raw = (i < 7) ? pat[i] : 1'b0;
      tick();
      n_checks++;
      if (button_a !== 1'b0 || cnt_a !== 8'(c0))
        $display("FAIL bounce cycle %0d: got button=%b count=%0d want 0/%0d", i, button_a, cnt_a, c0);
      else n_pass++;
    end
  endtask

  task automatic test_press_during_service();
    int c0;
    c0 = m_cnt_a;
    green_p = 1'b1; button_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (button_a !== 1'b0) $display("FAIL pds_button: got %b want 0", button_a);
      else n_pass++;
    end
    n_checks++;
    if (cnt_a !== 8'(c0 + 1)) $display("FAIL pds_count: got %0d want %0d", cnt_a, c0 + 1);
    else n_pass++;
    green_p = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (button_a !== 1'b0) $display("FAIL pds_after: got %b want 0", button_a);
      else n_pass++;
    end
    button_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_saturation_and_reset();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      button_raw = 1'b1; repeat (8) tick();
      button_raw = 1'b0; repeat (8) tick();
    end
    n_checks++;
    if (cnt_b !== 2'd3) $display("FAIL sat_count_w2: got %0d want 3", cnt_b);
    else n_pass++;
    n_checks++;
    if (cnt_a !== 8'd5) $display("FAIL sat_count_w8: got %0d want 5", cnt_a);
    else n_pass++;
    n_checks++;
    if (button_b !== 1'b1) $display("FAIL sat_button: got %b want 1", button_b);
    else n_pass++;
    button_raw = 1'b1;
    repeat (2) tick();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    n_checks++;
    if (cnt_b !== 2'd0 || cnt_a !== 8'd0 || button_b !== 1'b0)
      $display("FAIL midreset: got count=%0d/%0d button=%b want 0/0/0", cnt_a, cnt_b, button_b);
    else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (button_b !== (k >= 6) || cnt_b !== ((k >= 6) ? 2'd1 : 2'd0))
        $display("FAIL post_midreset edge %0d: got button=%b count=%0d want %b/%0d",
                 k, button_b, cnt_b, (k >= 6), (k >= 6) ? 1 : 0);
      else n_pass++;
    end
    button_raw = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        button_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 7);
      end
      hold--;
      green_p = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (button_a !== m_req || button_b !== m_req)
        $display("FAIL rand_button cycle %0d: got %b/%b want %b", c, button_a, button_b, m_req);
      else n_pass++;
      n_checks++;
      if (cnt_a !== 8'(m_cnt_a) || cnt_b !== 2'(m_cnt_b))
        $display("FAIL rand_count cycle %0d: got %0d/%0d want %0d/%0d", c, cnt_a, cnt_b, m_cnt_a, m_cnt_b);
      else n_pass++;
    end
    rst = 1'b0; green_p = 1'b0; button_raw = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_service();
    test_bounce();
    test_press_during_service();
    test_saturation_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
